// File: rtl/hood_mode_ctrl_if.sv
// Hood mode controller bus: press pulses, power level and 1 s tick in,
// mode / fan / countdown / status out.
interface hood_mode_ctrl_if;
    logic       tick_1s;
    logic       power_on;
    logic       menu_btn;
    logic       lvl1_btn;
    logic       lvl2_btn;
    logic       lvl3_btn;
    logic       clean_btn;
    logic [2:0] mode;
    logic [1:0] fan_speed;
    logic [7:0] countdown;
    logic       lvl3_used;
    logic       clean_done;
    logic       remind;

    // Driver side (input block / testbench)
    modport master (
        output tick_1s, power_on, menu_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn,
        input  mode, fan_speed, countdown, lvl3_used, clean_done, remind
    );

    // Controller side
    modport slave (
        input  tick_1s, power_on, menu_btn, lvl1_btn, lvl2_btn, lvl3_btn, clean_btn,
        output mode, fan_speed, countdown, lvl3_used, clean_done, remind
    );
endinterface

// File: rtl/hood_mode_ctrl.sv
// Range hood mode controller: power/menu/fan-level/boost/cooldown/self-clean
// state machine with registered outputs.
// Optional macro HOOD_REMIND_EN adds a fan run-time accumulator that raises
// a cleaning reminder after T_REMIND fan-run seconds.
module hood_mode_ctrl #(
    parameter logic [7:0]  T_STORM  = 8'd60,
    parameter logic [7:0]  T_COOL   = 8'd60,
    parameter logic [7:0]  T_CLEAN  = 8'd180,
    parameter logic [15:0] T_REMIND = 16'd36000
) (
    input  logic              clk,
    input  logic              reset,
    hood_mode_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        STANDBY = 3'd1,
        MENU    = 3'd2,
        LVL1    = 3'd3,
        LVL2    = 3'd4,
        LVL3    = 3'd5,
        COOL    = 3'd6,
        CLEAN   = 3'd7
    } mode_t;

    mode_t      state;
    logic [1:0] fan_q;
    logic [7:0] cnt_q;
    logic       used_q;
    logic       done_q;
    logic       remind_q;

    // Timer expiry: the last tick of a running countdown. Beats any button.
    logic expire;
    logic cnt_dec;
    assign expire  = bus.tick_1s && (cnt_q == 8'd1);
    assign cnt_dec = bus.tick_1s && (cnt_q != 8'd0);

    // Mode FSM; fan speed is written together with each mode change so it
    // always matches the registered mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= OFF;
            fan_q  <= 2'd0;
            cnt_q  <= 8'd0;
            used_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!bus.power_on) begin
                state  <= OFF;
                fan_q  <= 2'd0;
                cnt_q  <= 8'd0;
                used_q <= 1'b0;
            end else begin
                unique case (state)
                    OFF: begin
                        state <= STANDBY;
                        fan_q <= 2'd0;
                    end
                    STANDBY: begin
                        if (bus.menu_btn) state <= MENU;
                    end
                    MENU: begin
                        // lvl3 falls through to lower buttons once consumed
                        if (bus.menu_btn) begin
                            state <= STANDBY;
                        end else if (bus.lvl3_btn && !used_q) begin
                            state  <= LVL3;
                            fan_q  <= 2'd3;
                            cnt_q  <= T_STORM;
                            used_q <= 1'b1;
                        end else if (bus.lvl2_btn) begin
                            state <= LVL2;
                            fan_q <= 2'd2;
                        end else if (bus.lvl1_btn) begin
                            state <= LVL1;
                            fan_q <= 2'd1;
                        end else if (bus.clean_btn) begin
                            state <= CLEAN;
                            fan_q <= 2'd0;
                            cnt_q <= T_CLEAN;
                        end
                    end
                    LVL1, LVL2: begin
                        if (bus.menu_btn) begin
                            state <= STANDBY;
                            fan_q <= 2'd0;
                        end else if (bus.lvl1_btn) begin
                            state <= LVL1;
                            fan_q <= 2'd1;
                        end else if (bus.lvl2_btn) begin
                            state <= LVL2;
                            fan_q <= 2'd2;
                        end
                    end
                    LVL3: begin
                        if (expire) begin
                            state <= LVL2;
                            fan_q <= 2'd2;
                            cnt_q <= 8'd0;
                        end else if (bus.menu_btn) begin
                            state <= COOL;
                            fan_q <= 2'd2;
                            cnt_q <= T_COOL;
                        end else if (cnt_dec) begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    COOL: begin
                        if (expire) begin
                            state <= STANDBY;
                            fan_q <= 2'd0;
                            cnt_q <= 8'd0;
                        end else if (cnt_dec) begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    CLEAN: begin
                        if (expire) begin
                            state  <= STANDBY;
                            fan_q  <= 2'd0;
                            cnt_q  <= 8'd0;
                            done_q <= 1'b1;
                        end else if (cnt_dec) begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    default: begin
                        state <= OFF;
                        fan_q <= 2'd0;
                        cnt_q <= 8'd0;
                    end
                endcase
            end
        end
    end

`ifdef HOOD_REMIND_EN
    logic [15:0] acc_q;

    // Fan run-time accumulator; survives power-off, cleared by a finished clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= 16'd0;
            remind_q <= 1'b0;
        end else if (done_q) begin
            acc_q    <= 16'd0;
            remind_q <= 1'b0;
        end else if (bus.tick_1s && (fan_q != 2'd0) && (acc_q < T_REMIND)) begin
            acc_q <= acc_q + 16'd1;
            if (acc_q + 16'd1 == T_REMIND) remind_q <= 1'b1;
        end
    end
`else
    logic unused_remind_cfg;
    assign unused_remind_cfg = ^T_REMIND;
    assign remind_q = 1'b0;
`endif

    assign bus.mode       = state;
    assign bus.fan_speed  = fan_q;
    assign bus.countdown  = cnt_q;
    assign bus.lvl3_used  = used_q;
    assign bus.clean_done = done_q;
    assign bus.remind     = remind_q;

endmodule
